seq_chunk_adder: RTL



---
 rtl/seq_chunk_adder_if.sv | 44 ++++
 rtl/seq_chunk_adder.sv | 134 +++++++++++++
 2 files changed

// File: rtl/seq_chunk_adder_if.sv
// ============================================================================
//  seq_chunk_adder_if : operand/result handshake bundle for seq_chunk_adder
//  Optional `sub` signal present when SEQ_CHUNK_ADDER_SUB_EN is defined.
//  Rev 1.0
// ============================================================================
`default_nettype none

interface seq_chunk_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin,
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin,
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

`default_nettype wire

// File: rtl/seq_chunk_adder.sv
// ============================================================================
//  seq_chunk_adder : multi-cycle ripple adder, one CHUNK-bit slice per clock.
//  Optional subtract mode via macro SEQ_CHUNK_ADDER_SUB_EN.
//  Rev 1.0
// ============================================================================
`default_nettype none

module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic              clk,
  input  logic              rst,
  seq_chunk_adder_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [IDXW-1:0]  idx_q;

  logic [CHUNK:0]   chunk_d;
  logic             msb_cin_d;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] b_in_d;

  // Operands shift right one slice per cycle so the active slice is always
  // in the low bits; result slices enter sum from the top and land in place
  // after the last slice.
  assign chunk_d   = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_q};
  assign msb_cin_d = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ chunk_d[CHUNK-1];

  generate
    if (NCHUNK == 1) begin : g_single
      assign a_d   = '0;
      assign b_d   = '0;
      assign sum_d = chunk_d[CHUNK-1:0];
    end else begin : g_multi
      assign a_d   = {{CHUNK{1'b0}}, a_q[WIDTH-1:CHUNK]};
      assign b_d   = {{CHUNK{1'b0}}, b_q[WIDTH-1:CHUNK]};
      assign sum_d = {chunk_d[CHUNK-1:0], sum_q[WIDTH-1:CHUNK]};
    end
  endgenerate

`ifdef SEQ_CHUNK_ADDER_SUB_EN
  assign b_in_d = bus.sub ? ~bus.b : bus.b;
`else
  assign b_in_d = bus.b;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= b_in_d;
            carry_q    <= bus.cin;
            sum_q      <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_ADD;
          end
        end
        S_ADD: begin
          a_q     <= a_d;
          b_q     <= b_d;
          sum_q   <= sum_d;
          carry_q <= chunk_d[CHUNK];
          if (idx_q == LAST_IDX) begin
            idx_q       <= '0;
            cout_q      <= chunk_d[CHUNK];
            ovf_q       <= msb_cin_d ^ chunk_d[CHUNK];
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

`default_nettype wire
